// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_streamer
// Description : Output stage for the matrix multiplier. Captures the flattened
//               M x N result matrix on the done_in pulse, then streams the
//               elements out one per cycle in row-major order over a
//               valid/ready handshake. Each element is logically right-shifted
//               by SHIFT and saturated to OUT_WIDTH bits.
//
// Ports       :
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   done_in    in   one-cycle pulse, C_flat valid this cycle
//   C_flat     in   result matrix, element (r,c) at [(r*N+c)*ACC_WIDTH +: ACC_WIDTH]
//   busy       out  high from capture until the last element is accepted
//   out_valid  out  output element valid
//   out_ready  in   consumer accepts the element
//   out_data   out  scaled and saturated element
//   out_sat    out  current element was clipped
//   out_row    out  row index of the current element
//   out_col    out  column index of the current element
//   out_last   out  current element is (M-1, N-1)
//   overrun    out  one-cycle pulse when a done_in is dropped
//
// Revision    : 1.0 - initial release
// ============================================================================

module matrix_result_streamer #(
    parameter int M         = 6,
    parameter int N         = 6,
    parameter int ACC_WIDTH = 35,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done_in,
    input  logic [M*N*ACC_WIDTH-1:0]     C_flat,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_sat,
    output logic [$clog2(M):0]           out_row,
    output logic [$clog2(N):0]           out_col,
    output logic                         out_last,
    output logic                         overrun
);

    localparam int c_num_elem = M * N;
    localparam int c_idx_w    = (c_num_elem > 1) ? $clog2(c_num_elem) : 1;
    localparam int c_row_w    = $clog2(M) + 1;
    localparam int c_col_w    = $clog2(N) + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [c_idx_w-1:0]     idx_q,   idx_d;
    logic [c_row_w-1:0]     row_q,   row_d;
    logic [c_col_w-1:0]     col_q,   col_d;
    logic                   overrun_q, overrun_d;
    logic [ACC_WIDTH-1:0]   buf_q [c_num_elem];

    logic                   w_capture;
    logic                   w_streaming;
    logic                   w_handshake;
    logic                   w_at_last;
    logic                   w_col_wrap;

    assign w_streaming = (state_q == ST_STREAM);
    assign w_handshake = w_streaming && out_ready;
    assign w_col_wrap  = (col_q == c_col_w'(N - 1));
    assign w_at_last   = (row_q == c_row_w'(M - 1)) && w_col_wrap;

    // ------------------------------------------------------------------------
    // Next-state logic
    // Row/column are tracked as counters next to the flat index so that no
    // divider is needed to decode the index.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = 1'b0;
        w_capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (done_in) begin
                    w_capture = 1'b1;
                    state_d   = ST_STREAM;
                    idx_d     = '0;
                    row_d     = '0;
                    col_d     = '0;
                end
            end

            ST_STREAM: begin
                if (w_handshake && w_at_last) begin
                    // Final handshake: either finish, or take a new matrix
                    // straight away so out_valid carries on without a bubble.
                    idx_d = '0;
                    row_d = '0;
                    col_d = '0;
                    if (done_in) begin
                        w_capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (w_handshake) begin
                        idx_d = idx_q + c_idx_w'(1);
                        if (w_col_wrap) begin
                            col_d = '0;
                            row_d = row_q + c_row_w'(1);
                        end else begin
                            col_d = col_q + c_col_w'(1);
                        end
                    end
                    // Buffer is still in use, so a new result is dropped.
                    overrun_d = done_in;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Capture buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_num_elem; i++) begin
                buf_q[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < c_num_elem; i++) begin
                buf_q[i] <= C_flat[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scaling and saturation of the current element
    // ------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] w_elem;
    logic [ACC_WIDTH-1:0] w_shifted;
    logic [OUT_WIDTH-1:0] w_scaled;
    logic                 w_clip;

    assign w_elem    = buf_q[idx_q];
    assign w_shifted = w_elem >> SHIFT;

    generate
        if (OUT_WIDTH >= ACC_WIDTH) begin : g_wide
            // Every shifted value fits: zero-extend, never clip.
            assign w_scaled = OUT_WIDTH'(w_shifted);
            assign w_clip   = 1'b0;
        end else begin : g_narrow
            // When SHIFT clears all the bits above OUT_WIDTH the OR below
            // reduces to a constant 0 and the clip path disappears.
            logic w_over;
            assign w_over   = |w_shifted[ACC_WIDTH-1:OUT_WIDTH];
            assign w_scaled = w_over ? {OUT_WIDTH{1'b1}} : w_shifted[OUT_WIDTH-1:0];
            assign w_clip   = w_over;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only. Element fields are forced
    // to zero while idle so they read as their reset values between streams.
    // ------------------------------------------------------------------------
    assign busy      = w_streaming;
    assign out_valid = w_streaming;
    assign out_data  = w_streaming ? w_scaled : '0;
    assign out_sat   = w_streaming && w_clip;
    assign out_row   = w_streaming ? row_q : '0;
    assign out_col   = w_streaming ? col_q : '0;
    assign out_last  = w_streaming && w_at_last;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_result_streamer
// Description : Self-checking bench for matrix_result_streamer. Two 2x2
//               instances (SHIFT=0 and SHIFT=4) share the same stimulus. A
//               queue-based model predicts every output cycle by cycle, and
//               directed scenarios add literal checks at key cycles.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_matrix_result_streamer;

    localparam int M  = 2;
    localparam int N  = 2;
    localparam int AW = 35;
    localparam int OW = 16;
    localparam int NE = M * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              done_in;
    logic              out_ready;
    logic [NE*AW-1:0]  C_flat;

    logic          busy_a, valid_a, sat_a, last_a, ovr_a;
    logic [OW-1:0] data_a;
    logic [1:0]    row_a, col_a;
    logic          busy_b, valid_b, sat_b, last_b, ovr_b;
    logic [OW-1:0] data_b;
    logic [1:0]    row_b, col_b;

    matrix_result_streamer #(
        .M(M), .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .done_in(done_in), .C_flat(C_flat),
        .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
        .out_data(data_a), .out_sat(sat_a), .out_row(row_a), .out_col(col_a),
        .out_last(last_a), .overrun(ovr_a)
    );

    matrix_result_streamer #(
        .M(M), .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .done_in(done_in), .C_flat(C_flat),
        .busy(busy_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_data(data_b), .out_sat(sat_b), .out_row(row_b), .out_col(col_b),
        .out_last(last_b), .overrun(ovr_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: a queue of elements still owed to the consumer
    // ------------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] elem;
        int            row;
        int            col;
        bit            last;
    } exp_t;

    exp_t q[$];
    bit   exp_ovr = 1'b0;
    bit   chk_en  = 1'b0;
    bit   m_hs, m_fin, m_acc;

    // Returns {sat, data}
    function automatic logic [OW:0] scale(input logic [AW-1:0] e, input int sh);
        logic [AW-1:0] s;
        s = e >> sh;
        if (s > 65535) return {1'b1, 16'hFFFF};
        return {1'b0, s[OW-1:0]};
    endfunction

    task automatic cmp_dut(input string tag, input int sh,
                           input logic busy, input logic v, input logic [OW-1:0] d,
                           input logic s, input logic [1:0] r, input logic [1:0] c,
                           input logic l, input logic o);
        logic [OW:0] sd;
        if (q.size() > 0) begin
            sd = scale(q[0].elem, sh);
            check({tag, "_valid"}, 64'(v), 1);
            check({tag, "_busy"},  64'(busy), 1);
            check({tag, "_data"},  64'(d), 64'(sd[OW-1:0]));
            check({tag, "_sat"},   64'(s), 64'(sd[OW]));
            check({tag, "_row"},   64'(r), 64'(q[0].row));
            check({tag, "_col"},   64'(c), 64'(q[0].col));
            check({tag, "_last"},  64'(l), 64'(q[0].last));
        end else begin
            check({tag, "_valid"}, 64'(v), 0);
            check({tag, "_busy"},  64'(busy), 0);
            check({tag, "_data"},  64'(d), 0);
            check({tag, "_sat"},   64'(s), 0);
            check({tag, "_row"},   64'(r), 0);
            check({tag, "_col"},   64'(c), 0);
            check({tag, "_last"},  64'(l), 0);
        end
        check({tag, "_overrun"}, 64'(o), 64'(exp_ovr));
    endtask

    // Compare on the falling edge, then advance the model using the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("A", 0, busy_a, valid_a, data_a, sat_a, row_a, col_a, last_a, ovr_a);
            cmp_dut("B", 4, busy_b, valid_b, data_b, sat_b, row_b, col_b, last_b, ovr_b);
            m_hs = (q.size() > 0) && out_ready;
            if (rst) begin
                q.delete();
                exp_ovr = 1'b0;
            end else begin
                m_fin   = m_hs && (q.size() == 1);
                m_acc   = done_in && ((q.size() == 0) || m_fin);
                exp_ovr = done_in && !m_acc;
                if (m_hs) void'(q.pop_front());
                if (m_acc) begin
                    for (int i = 0; i < NE; i++) begin
                        q.push_back('{elem: C_flat[i*AW +: AW], row: i / N,
                                      col: i % N, last: (i == NE - 1)});
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                         input logic [AW-1:0] e2, input logic [AW-1:0] e3);
        C_flat = {e3, e2, e1, e0};
    endtask

    // done_in pulse; returns in cycle 1 (first element showing)
    task automatic start();
        done_in = 1'b1;
        step();
        done_in = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        done_in   = 1'b0;
        out_ready = 1'b0;
        C_flat    = '0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_valid", 64'(valid_a), 0);
        check("rst_busy",  64'(busy_a), 0);
        check("rst_data",  64'(data_a), 0);
        check("rst_ovr",   64'(ovr_a), 0);
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        check("idle_ready_ignored", 64'(valid_a), 0);

        // Basic stream
        set_c(1, 2, 3, 4);
        start();
        check("basic_c1_data", 64'(data_a), 1);
        check("basic_c1_row",  64'(row_a), 0);
        check("basic_c1_col",  64'(col_a), 0);
        step();
        check("basic_c2_data", 64'(data_a), 2);
        check("basic_c2_col",  64'(col_a), 1);
        step();
        step();
        check("basic_c4_data", 64'(data_a), 4);
        check("basic_c4_last", 64'(last_a), 1);
        check("basic_c4_row",  64'(row_a), 1);
        step();
        check("basic_c5_busy", 64'(busy_a), 0);
        step();

        // Backpressure: out_ready low for cycles 2-3
        set_c(1, 2, 3, 4);
        start();
        step();
        out_ready = 1'b0;
        step();
        step();
        check("bp_c4_hold", 64'(data_a), 2);
        out_ready = 1'b1;
        step();
        check("bp_c5_data", 64'(data_a), 3);
        step();
        check("bp_c6_last", 64'(last_a), 1);
        step();
        check("bp_c7_valid", 64'(valid_a), 0);
        step();

        // Scaling and saturation
        set_c(35'd70000, 35'h120, 35'h1FFFF0, 35'h7_FFFF_FFFF);
        start();
        check("sat_e0_a_data", 64'(data_a), 65535);
        check("sat_e0_a_sat",  64'(sat_a), 1);
        check("sat_e0_b_data", 64'(data_b), 4375);
        check("sat_e0_b_sat",  64'(sat_b), 0);
        step();
        check("sat_e1_a_data", 64'(data_a), 288);
        check("sat_e1_b_data", 64'(data_b), 'h12);
        check("sat_e1_b_sat",  64'(sat_b), 0);
        step();
        check("sat_e2_a_sat",  64'(sat_a), 1);
        check("sat_e2_b_data", 64'(data_b), 'hFFFF);
        check("sat_e2_b_sat",  64'(sat_b), 1);
        step();
        check("sat_e3_b_sat",  64'(sat_b), 1);
        step();
        step();

        // Overrun: second done_in at cycle 2
        set_c(1, 2, 3, 4);
        start();
        step();
        set_c(9, 9, 9, 9);
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        check("ovr_c3_pulse", 64'(ovr_a), 1);
        check("ovr_c3_data",  64'(data_a), 3);
        step();
        check("ovr_c4_clear", 64'(ovr_a), 0);
        check("ovr_c4_data",  64'(data_a), 4);
        step();
        step();

        // Back-to-back: new done_in in the final-handshake cycle
        set_c(1, 2, 3, 4);
        start();
        step();
        step();
        step();
        set_c(5, 6, 7, 8);
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        check("b2b_c5_valid", 64'(valid_a), 1);
        check("b2b_c5_data",  64'(data_a), 5);
        check("b2b_c5_ovr",   64'(ovr_a), 0);
        step();
        step();
        step();
        check("b2b_c8_data", 64'(data_a), 8);
        step();
        check("b2b_c9_valid", 64'(valid_a), 0);
        step();

        // done_in on last element while stalled: dropped
        set_c(1, 2, 3, 4);
        start();
        step();
        step();
        step();
        out_ready = 1'b0;
        set_c(5, 6, 7, 8);
        done_in   = 1'b1;
        step();
        done_in = 1'b0;
        check("stall_last_ovr",  64'(ovr_a), 1);
        check("stall_last_data", 64'(data_a), 4);
        out_ready = 1'b1;
        step();
        check("stall_last_done", 64'(valid_a), 0);
        step();

        // Reset mid-stream
        set_c(1, 2, 3, 4);
        start();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstm_valid", 64'(valid_a), 0);
        check("rstm_busy",  64'(busy_a), 0);
        check("rstm_data",  64'(data_a), 0);
        check("rstm_last",  64'(last_a), 0);
        set_c(5, 6, 7, 8);
        start();
        check("rstm_restart_data", 64'(data_a), 5);
        check("rstm_restart_row",  64'(row_a), 0);
        check("rstm_restart_col",  64'(col_a), 0);
        repeat (5) step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
